// File: rtl/hex_decoder_pkg.sv
// Shared constants for the single-digit seven-segment driver.
// Holds the mode encoding, the "display dark" values and the glyph table.
package hex_decoder_pkg;

    typedef enum logic [1:0] {
        MODE_A   = 2'd0,
        MODE_B   = 2'd1,
        MODE_SUM = 2'd2,
        MODE_XOR = 2'd3
    } mode_e;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    // Active-low glyphs ordered {g,f,e,d,c,b,a}; entry n is at slice [n].
    // b and d are the lowercase glyphs so they differ from 8 and 0.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

endpackage

// File: rtl/hex_decoder_if.sv
// Switch/display bundle between the board pins and hex_decoder.
// master drives the switches and watches the display; slave is the decoder.
interface hex_decoder_if;

    logic [9:0] sw;
    logic [6:0] hex;
    logic [7:0] AN;

    modport master (output sw, input hex, input AN);
    modport slave  (input sw, output hex, output AN);

endinterface

// File: rtl/hex_decoder_seg7_rom.sv
// Combinational nibble-to-segment lookup (active-low, {g,f,e,d,c,b,a}).
module seg7_rom
    import hex_decoder_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);

    // Straight table lookup; every nibble has a defined glyph.
    always_comb begin
        seg = SEG_TABLE[value];
    end

endmodule

// File: rtl/hex_decoder.sv
// Single-digit seven-segment driver: selects A, B, A+B or A^B from the
// switches, encodes the nibble and lights the digit matching the mode.
// Optional build macro: HEX_DECODER_ZERO_BLANK_EN blanks the digit when the
// selected value is zero (the anode is still driven).
module hex_decoder
    import hex_decoder_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    hex_decoder_if.slave    bus
);

    logic [3:0] op_a;
    logic [3:0] op_b;
    mode_e      mode;
    logic [3:0] value;
    logic [6:0] seg_raw;
    logic [6:0] seg_next;
    logic [7:0] an_next;
    logic [6:0] hex_p1;
    logic [7:0] an_p1;

    assign op_a = bus.sw[3:0];
    assign op_b = bus.sw[7:4];
    assign mode = mode_e'(bus.sw[9:8]);

    // Mode mux; the sum is 4 bits wide so the carry falls off naturally.
    always_comb begin
        value = op_a;
        case (mode)
            MODE_A:   value = op_a;
            MODE_B:   value = op_b;
            MODE_SUM: value = op_a + op_b;
            MODE_XOR: value = op_a ^ op_b;
            default:  value = op_a;
        endcase
    end

    seg7_rom u_rom (
        .value (value),
        .seg   (seg_raw)
    );

    // Optional zero blanking and the one-cold anode decode.
    always_comb begin
`ifdef HEX_DECODER_ZERO_BLANK_EN
        seg_next = (value == 4'd0) ? SEG_OFF : seg_raw;
`else
        seg_next = seg_raw;
`endif
        an_next = ~(8'b1 << bus.sw[9:8]);
    end

    // ---- stage p1: output registers, forced dark while in reset ----
    always_ff @(posedge clk) begin
        if (rst) begin
            hex_p1 <= SEG_OFF;
            an_p1  <= AN_OFF;
        end else begin
            hex_p1 <= seg_next;
            an_p1  <= an_next;
        end
    end

    assign bus.hex = hex_p1;
    assign bus.AN  = an_p1;

endmodule

// File: tb/tb_hex_decoder.sv
// Self-checking bench for hex_decoder: directed mode cases, reset behaviour
// and a random sweep, all checked through an expected-value queue.
module tb_hex_decoder;

    typedef struct packed {
        logic [6:0] hex;
        logic [7:0] an;
    } exp_t;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;
    exp_t sb[$];

    hex_decoder_if bus ();

    hex_decoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference glyph table, written out independently of the design package.
    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;  4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;  4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;  4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;  4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;  default: glyph = 7'h0E;
        endcase
    endfunction

    function automatic exp_t model(input logic r, input logic [9:0] s);
        exp_t       e;
        logic [4:0] sum;
        logic [3:0] v;
        if (r) begin
            e.hex = 7'h7F;
            e.an  = 8'hFF;
        end else begin
            sum = {1'b0, s[3:0]} + {1'b0, s[7:4]};
            case (s[9:8])
                2'd0: begin v = s[3:0];          e.an = 8'hFE; end
                2'd1: begin v = s[7:4];          e.an = 8'hFD; end
                2'd2: begin v = sum[3:0];        e.an = 8'hFB; end
                default: begin v = s[3:0] ^ s[7:4]; e.an = 8'hF7; end
            endcase
            e.hex = glyph(v);
`ifdef HEX_DECODER_ZERO_BLANK_EN
            if (v == 4'd0) e.hex = 7'h7F;
`endif
        end
        return e;
    endfunction

    // Drive one cycle of stimulus, record its expectation, advance past the edge.
    task automatic drive(input logic r, input logic [9:0] s);
        rst    = r;
        bus.sw = s;
        sb.push_back(model(r, s));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 10'h3FF);
            e = sb.pop_front();
            total_cnt++;
            if (bus.hex !== e.hex || bus.AN !== e.an)
                $display("FAIL reset_hold[%0d] hex=%h AN=%h expected hex=%h AN=%h", i, bus.hex, bus.AN, e.hex, e.an);
            else pass_cnt++;
        end
        drive(1'b0, 10'h3FF);
        e = sb.pop_front();
        total_cnt++;
        if (bus.hex !== e.hex || bus.AN !== e.an)
            $display("FAIL reset_release hex=%h AN=%h expected hex=%h AN=%h", bus.hex, bus.AN, e.hex, e.an);
        else pass_cnt++;
    endtask

    task automatic test_mode_a();
        exp_t e;
        drive(1'b0, 10'h095);
        e = sb.pop_front();
        total_cnt++;
        if (bus.hex !== 7'h12 || bus.AN !== 8'hFE || e.hex !== 7'h12)
            $display("FAIL mode_a_095 hex=%h AN=%h expected hex=12 AN=FE", bus.hex, bus.AN);
        else pass_cnt++;
        for (int a = 0; a < 16; a++) begin
            drive(1'b0, {2'b00, 4'h9, 4'(a)});
            e = sb.pop_front();
            total_cnt++;
            if (bus.hex !== e.hex || bus.AN !== e.an)
                $display("FAIL mode_a_step[%0d] hex=%h AN=%h expected hex=%h AN=%h", a, bus.hex, bus.AN, e.hex, e.an);
            else pass_cnt++;
        end
    endtask

    task automatic test_mode_b();
        exp_t e;
        drive(1'b0, 10'h1C3);
        e = sb.pop_front();
        total_cnt++;
        if (bus.hex !== 7'h46 || bus.AN !== 8'hFD || bus.hex !== e.hex)
            $display("FAIL mode_b_1C3 hex=%h AN=%h expected hex=46 AN=FD", bus.hex, bus.AN);
        else pass_cnt++;
    endtask

    task automatic test_mode_sum();
        exp_t e;
        drive(1'b0, 10'h289);
        e = sb.pop_front();
        total_cnt++;
        if (bus.hex !== 7'h79 || bus.AN !== 8'hFB || bus.hex !== e.hex)
            $display("FAIL sum_wrap_9p8 hex=%h AN=%h expected hex=79 AN=FB", bus.hex, bus.AN);
        else pass_cnt++;
        drive(1'b0, 10'h21F);
        e = sb.pop_front();
        total_cnt++;
`ifdef HEX_DECODER_ZERO_BLANK_EN
        if (bus.hex !== 7'h7F || bus.AN !== 8'hFB || bus.hex !== e.hex)
            $display("FAIL sum_wrap_Fp1 hex=%h AN=%h expected hex=7F AN=FB", bus.hex, bus.AN);
`else
        if (bus.hex !== 7'h40 || bus.AN !== 8'hFB || bus.hex !== e.hex)
            $display("FAIL sum_wrap_Fp1 hex=%h AN=%h expected hex=40 AN=FB", bus.hex, bus.AN);
`endif
        else pass_cnt++;
    endtask

    task automatic test_mode_xor();
        exp_t e;
        drive(1'b0, 10'h36A);
        e = sb.pop_front();
        total_cnt++;
        if (bus.hex !== 7'h46 || bus.AN !== 8'hF7 || bus.hex !== e.hex)
            $display("FAIL xor_A6 hex=%h AN=%h expected hex=46 AN=F7", bus.hex, bus.AN);
        else pass_cnt++;
        drive(1'b0, 10'h377);
        e = sb.pop_front();
        total_cnt++;
        if (bus.hex !== e.hex || bus.AN !== 8'hF7)
            $display("FAIL xor_77 hex=%h AN=%h expected hex=%h AN=F7", bus.hex, bus.AN, e.hex);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        drive(1'b0, 10'h289);
        e = sb.pop_front();
        total_cnt++;
        if (bus.hex !== e.hex || bus.AN !== e.an)
            $display("FAIL mid_pre hex=%h AN=%h expected hex=%h AN=%h", bus.hex, bus.AN, e.hex, e.an);
        else pass_cnt++;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 10'h36A);
            e = sb.pop_front();
            total_cnt++;
            if (bus.hex !== 7'h7F || bus.AN !== 8'hFF || e.an !== 8'hFF)
                $display("FAIL mid_reset[%0d] hex=%h AN=%h expected hex=7F AN=FF", i, bus.hex, bus.AN);
            else pass_cnt++;
        end
        drive(1'b0, 10'h36A);
        e = sb.pop_front();
        total_cnt++;
        if (bus.hex !== e.hex || bus.AN !== e.an)
            $display("FAIL mid_release hex=%h AN=%h expected hex=%h AN=%h", bus.hex, bus.AN, e.hex, e.an);
        else pass_cnt++;
    endtask

    task automatic test_random();
        exp_t        e;
        logic [7:0]  ops;
        logic [9:0]  s;
        for (int blk = 0; blk < 48; blk++) begin
            ops = 8'($urandom_range(0, 255));
            s   = {2'((blk / 4) % 4), ops};
            for (int c = 0; c < 10; c++) begin
                drive(1'b0, s);
                e = sb.pop_front();
                total_cnt++;
                if (bus.hex !== e.hex || bus.AN !== e.an)
                    $display("FAIL rand[%0d.%0d] sw=%h hex=%h AN=%h expected hex=%h AN=%h", blk, c, s, bus.hex, bus.AN, e.hex, e.an);
                else pass_cnt++;
                total_cnt++;
                if (bus.AN[7:4] !== 4'hF || $countones(~bus.AN[3:0]) != 1)
                    $display("FAIL rand_onecold[%0d.%0d] AN=%h expected one zero in AN[3:0]", blk, c, bus.AN);
                else pass_cnt++;
            end
        end
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst       = 1'b1;
        bus.sw    = 10'h000;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_mode_a();
        test_mode_b();
        test_mode_sum();
        test_mode_xor();
        test_reset_mid();
        test_random();
        total_cnt++;
        if (sb.size() != 0)
            $display("FAIL scoreboard_drain left=%0d expected 0", sb.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
